// File: rtl/calc_control.sv
// Keypad sequencing controller: turns key events into registered memory
// strobes and runs the ALU request/response handshake on equals.
module calc_control #(
  parameter int unsigned MAX_DIGITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [4:0] key_code,
  input  logic       res_valid,
  output logic       key_ready,
  output logic [3:0] num,
  output logic [1:0] operator,
  output logic [1:0] save_enable,
  output logic       equ_enable,
  output logic       clear_enable,
  output logic       op_enable,
  output logic [2:0] state_o
);

  localparam int unsigned DW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [2:0] {
    A_ENTRY = 3'd0,
    OP_SEL  = 3'd1,
    B_ENTRY = 3'd2,
    CALC    = 3'd3,
    RESULT  = 3'd4,
    RESTART = 3'd5
  } state_t;

  localparam logic [1:0] SAVE_IDLE = 2'b00;
  localparam logic [1:0] SAVE_ONE  = 2'b01;
  localparam logic [1:0] SAVE_OPR  = 2'b10;
  localparam logic [1:0] SAVE_TWO  = 2'b11;

  state_t        state_q;
  logic [DW-1:0] dcnt_q;
  logic [DW-1:0] dcnt_d;
  logic [3:0]    latch_q;
  logic [3:0]    num_q;
  logic [1:0]    opr_q;
  logic [1:0]    save_q;
  logic          equ_q;
  logic          clr_q;
  logic          open_q;
  logic          ready_q;

  logic k_dig;
  logic k_opr;
  logic k_equ;
  logic k_clr;
  logic dcnt_full;

  // Key classification; codes 0x16-0x1F fall through as no-ops.
  always_comb begin
    k_dig = 1'b0;
    k_opr = 1'b0;
    k_equ = 1'b0;
    k_clr = 1'b0;
    if (key_valid) begin
      unique case (1'b1)
        !key_code[4]:                 k_dig = 1'b1;
        key_code[4:2] == 3'b100:      k_opr = 1'b1;
        key_code == 5'h14:            k_equ = 1'b1;
        key_code == 5'h15:            k_clr = 1'b1;
        default: ;
      endcase
    end
  end

  assign dcnt_full = (dcnt_q == DW'(MAX_DIGITS));
  assign dcnt_d    = dcnt_q + DW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= A_ENTRY;
      dcnt_q  <= '0;
      latch_q <= 4'h0;
      num_q   <= 4'h0;
      opr_q   <= 2'b00;
      save_q  <= SAVE_IDLE;
      equ_q   <= 1'b0;
      clr_q   <= 1'b0;
      open_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      save_q <= SAVE_IDLE;
      equ_q  <= 1'b0;
      clr_q  <= 1'b0;
      if (k_clr) begin
        // Clear overrides whatever the current state had pending.
        state_q <= A_ENTRY;
        dcnt_q  <= '0;
        clr_q   <= 1'b1;
        open_q  <= 1'b0;
        ready_q <= 1'b1;
      end else begin
        unique case (state_q)
          A_ENTRY: begin
            if (k_dig && !dcnt_full) begin
              save_q <= SAVE_ONE;
              num_q  <= key_code[3:0];
              dcnt_q <= dcnt_d;
            end else if (k_opr) begin
              save_q  <= SAVE_OPR;
              opr_q   <= key_code[1:0];
              state_q <= OP_SEL;
            end
          end
          OP_SEL: begin
            if (k_opr) begin
              save_q <= SAVE_OPR;
              opr_q  <= key_code[1:0];
            end else if (k_dig) begin
              save_q  <= SAVE_TWO;
              num_q   <= key_code[3:0];
              dcnt_q  <= DW'(1);
              state_q <= B_ENTRY;
            end
          end
          B_ENTRY: begin
            if (k_dig && !dcnt_full) begin
              save_q <= SAVE_TWO;
              num_q  <= key_code[3:0];
              dcnt_q <= dcnt_d;
            end else if (k_equ) begin
              state_q <= CALC;
              open_q  <= 1'b1;
              ready_q <= 1'b0;
            end
          end
          CALC: begin
            if (res_valid) begin
              save_q  <= SAVE_ONE;
              equ_q   <= 1'b1;
              open_q  <= 1'b0;
              ready_q <= 1'b1;
              state_q <= RESULT;
            end
          end
          RESULT: begin
            // A fresh digit wipes memory first, then reloads it as operand A.
            if (k_dig) begin
              latch_q <= key_code[3:0];
              clr_q   <= 1'b1;
              ready_q <= 1'b0;
              state_q <= RESTART;
            end
          end
          RESTART: begin
            save_q  <= SAVE_ONE;
            num_q   <= latch_q;
            dcnt_q  <= DW'(1);
            ready_q <= 1'b1;
            state_q <= A_ENTRY;
          end
          default: begin
            state_q <= A_ENTRY;
            dcnt_q  <= '0;
            open_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign key_ready    = ready_q;
  assign num          = num_q;
  assign operator     = opr_q;
  assign save_enable  = save_q;
  assign equ_enable   = equ_q;
  assign clear_enable = clr_q;
  assign op_enable    = open_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_calc_control.sv
// Bench for calc_control: directed scenarios plus random keys checked
// against a session-level model of the calculator.
module tb_calc_control;

  localparam int MAXD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [4:0] key_code = 5'h00;
  logic       res_valid = 1'b0;
  logic       key_ready;
  logic [3:0] num;
  logic [1:0] operator;
  logic [1:0] save_enable;
  logic       equ_enable;
  logic       clear_enable;
  logic       op_enable;
  logic [2:0] state_o;

  int n_chk = 0;
  int n_pass = 0;

  calc_control #(.MAX_DIGITS(MAXD)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .res_valid(res_valid), .key_ready(key_ready), .num(num),
    .operator(operator), .save_enable(save_enable),
    .equ_enable(equ_enable), .clear_enable(clear_enable),
    .op_enable(op_enable), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Session model: operand lengths and phase flags, not a state register.
  int   a_len, b_len;
  bit   have_op, in_calc, in_result, in_restart;
  logic [3:0] held;
  logic [3:0] e_num;
  logic [1:0] e_op, e_save;
  bit   e_equ, e_clr, e_open, e_ready;
  logic [2:0] e_state;

  task automatic forget_session();
    a_len = 0; b_len = 0; have_op = 0;
    in_calc = 0; in_result = 0; in_restart = 0;
  endtask

  task automatic model(input bit r, input bit kv, input logic [4:0] kc,
                       input bit rv);
    e_save = 2'b00; e_equ = 0; e_clr = 0;
    if (r) begin
      forget_session(); e_num = 0; e_op = 0; held = 0;
    end else if (kv && kc == 5'h15) begin
      forget_session(); e_clr = 1;
    end else if (in_restart) begin
      in_restart = 0; a_len = 1; e_save = 2'b01; e_num = held;
    end else if (in_calc) begin
      if (rv) begin in_calc = 0; in_result = 1; e_save = 2'b01; e_equ = 1; end
    end else if (kv) begin
      if (in_result) begin
        if (kc < 16) begin
          forget_session(); in_restart = 1; held = kc[3:0]; e_clr = 1;
        end
      end else if (kc < 16) begin
        if (!have_op) begin
          if (a_len < MAXD) begin a_len++; e_save = 2'b01; e_num = kc[3:0]; end
        end else if (b_len < MAXD) begin
          b_len++; e_save = 2'b11; e_num = kc[3:0];
        end
      end else if (kc <= 5'h13) begin
        if (b_len == 0) begin have_op = 1; e_save = 2'b10; e_op = kc[1:0]; end
      end else if (kc == 5'h14) begin
        if (b_len > 0) in_calc = 1;
      end
    end
    e_state = in_restart ? 3'd5 : in_result ? 3'd4 : in_calc ? 3'd3 :
              (b_len > 0) ? 3'd2 : have_op ? 3'd1 : 3'd0;
    e_open  = in_calc;
    e_ready = !(in_calc || in_restart);
  endtask

  task automatic step(input bit r, input bit kv, input logic [4:0] kc,
                      input bit rv);
    rst = r; key_valid = kv; key_code = kc; res_valid = rv;
    @(posedge clk); #1;
    model(r, kv, kc, rv);
    rst = 0; key_valid = 0; key_code = 5'h00; res_valid = 0;
  endtask

  task automatic key(input logic [4:0] kc);
    step(0, 1, kc, 0);
  endtask

  task automatic idle();
    step(0, 0, 5'h00, 0);
  endtask

  task automatic test_reset();
    idle();
    step(1, 1, 5'h03, 1);
    n_chk++; if (num !== 4'h0) $display("FAIL reset_num got %0h want 0", num); else n_pass++;
    n_chk++; if (operator !== 2'b00) $display("FAIL reset_op got %0b want 00", operator); else n_pass++;
    n_chk++; if (save_enable !== 2'b00) $display("FAIL reset_save got %0b want 00", save_enable); else n_pass++;
    n_chk++; if (equ_enable !== 1'b0) $display("FAIL reset_equ got %0b want 0", equ_enable); else n_pass++;
    n_chk++; if (clear_enable !== 1'b0) $display("FAIL reset_clr got %0b want 0", clear_enable); else n_pass++;
    n_chk++; if (op_enable !== 1'b0) $display("FAIL reset_open got %0b want 0", op_enable); else n_pass++;
    n_chk++; if (key_ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", key_ready); else n_pass++;
    n_chk++; if (state_o !== 3'd0) $display("FAIL reset_state got %0d want 0", state_o); else n_pass++;
  endtask

  task automatic test_basic_calc();
    step(1, 0, 5'h00, 0);
    key(5'h01);
    n_chk++; if ({save_enable, num} !== {2'b01, 4'h1}) $display("FAIL basic_d1 got save %0b num %0h want 01/1", save_enable, num); else n_pass++;
    key(5'h02);
    n_chk++; if ({save_enable, num} !== {2'b01, 4'h2}) $display("FAIL basic_d2 got save %0b num %0h want 01/2", save_enable, num); else n_pass++;
    key(5'h10);
    n_chk++; if ({save_enable, operator, state_o} !== {2'b10, 2'b00, 3'd1}) $display("FAIL basic_add got save %0b op %0b st %0d want 10/00/1", save_enable, operator, state_o); else n_pass++;
    key(5'h03);
    n_chk++; if ({save_enable, num, state_o} !== {2'b11, 4'h3, 3'd2}) $display("FAIL basic_d3 got save %0b num %0h st %0d want 11/3/2", save_enable, num, state_o); else n_pass++;
    key(5'h14);
    n_chk++; if ({save_enable, op_enable, key_ready, state_o} !== {2'b00, 1'b1, 1'b0, 3'd3}) $display("FAIL basic_eq got save %0b open %0b rdy %0b st %0d want 00/1/0/3", save_enable, op_enable, key_ready, state_o); else n_pass++;
    idle();
    n_chk++; if (op_enable !== 1'b1) $display("FAIL basic_wait got open %0b want 1", op_enable); else n_pass++;
    step(0, 0, 5'h00, 1);
    n_chk++; if ({save_enable, equ_enable, op_enable, state_o} !== {2'b01, 1'b1, 1'b0, 3'd4}) $display("FAIL basic_res got save %0b equ %0b open %0b st %0d want 01/1/0/4", save_enable, equ_enable, op_enable, state_o); else n_pass++;
    idle();
    n_chk++; if ({save_enable, equ_enable} !== {2'b00, 1'b0}) $display("FAIL basic_res_end got save %0b equ %0b want 00/0", save_enable, equ_enable); else n_pass++;
  endtask

  task automatic test_digit_limit();
    int strobes = 0;
    step(1, 0, 5'h00, 0);
    for (int d = 1; d <= 5; d++) begin
      key(5'(d));
      if (save_enable == 2'b01) begin
        strobes++;
        n_chk++; if (num !== 4'(d)) $display("FAIL limit_num got %0h want %0h", num, d); else n_pass++;
      end
    end
    n_chk++; if (save_enable !== 2'b00) $display("FAIL limit_drop got save %0b want 00", save_enable); else n_pass++;
    n_chk++; if (strobes !== 4) $display("FAIL limit_count got %0d want 4", strobes); else n_pass++;
  endtask

  task automatic test_op_reselect();
    int strobes = 0;
    step(1, 0, 5'h00, 0);
    key(5'h10); if (save_enable == 2'b10) strobes++;
    key(5'h11); if (save_enable == 2'b10) strobes++;
    key(5'h12); if (save_enable == 2'b10) strobes++;
    n_chk++; if (strobes !== 3) $display("FAIL opsel_count got %0d want 3", strobes); else n_pass++;
    n_chk++; if ({operator, state_o} !== {2'b10, 3'd1}) $display("FAIL opsel_final got op %0b st %0d want 10/1", operator, state_o); else n_pass++;
  endtask

  task automatic reach_result();
    step(1, 0, 5'h00, 0);
    key(5'h05); key(5'h13); key(5'h02); key(5'h14);
    step(0, 0, 5'h00, 1);
  endtask

  task automatic test_restart();
    reach_result();
    key(5'h07);
    n_chk++; if ({clear_enable, key_ready, save_enable, state_o} !== {1'b1, 1'b0, 2'b00, 3'd5}) $display("FAIL restart_clr got clr %0b rdy %0b save %0b st %0d want 1/0/00/5", clear_enable, key_ready, save_enable, state_o); else n_pass++;
    idle();
    n_chk++; if ({save_enable, num, clear_enable, key_ready, state_o} !== {2'b01, 4'h7, 1'b0, 1'b1, 3'd0}) $display("FAIL restart_load got save %0b num %0h clr %0b rdy %0b st %0d want 01/7/0/1/0", save_enable, num, clear_enable, key_ready, state_o); else n_pass++;
  endtask

  task automatic test_calc_clear();
    step(1, 0, 5'h00, 0);
    key(5'h01); key(5'h10); key(5'h01); key(5'h14);
    key(5'h09);
    n_chk++; if ({save_enable, state_o} !== {2'b00, 3'd3}) $display("FAIL calc_digit got save %0b st %0d want 00/3", save_enable, state_o); else n_pass++;
    step(0, 1, 5'h15, 1);
    n_chk++; if ({clear_enable, equ_enable, save_enable, op_enable, state_o} !== {1'b1, 1'b0, 2'b00, 1'b0, 3'd0}) $display("FAIL calc_clear got clr %0b equ %0b save %0b open %0b st %0d want 1/0/00/0/0", clear_enable, equ_enable, save_enable, op_enable, state_o); else n_pass++;
  endtask

  task automatic test_rst_restart();
    reach_result();
    key(5'h07);
    step(1, 0, 5'h00, 0);
    n_chk++; if ({num, operator, save_enable, equ_enable, clear_enable, op_enable, key_ready, state_o} !== {4'h0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0}) $display("FAIL rst_restart got num %0h op %0b save %0b equ %0b clr %0b open %0b rdy %0b st %0d", num, operator, save_enable, equ_enable, clear_enable, op_enable, key_ready, state_o); else n_pass++;
    idle();
    n_chk++; if (save_enable !== 2'b00) $display("FAIL rst_restart_trail got save %0b want 00", save_enable); else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    step(1, 0, 5'h00, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r, kv, rv;
      logic [4:0] kc;
      r  = ($urandom_range(0, 299) == 0);
      kv = ($urandom_range(0, 9) < 7);
      rv = ($urandom_range(0, 9) < 3);
      kc = ($urandom_range(0, 3) == 0) ? 5'(16 + $urandom_range(0, 5))
                                       : 5'($urandom_range(0, 31));
      step(r, kv, kc, rv);
      n_chk++;
      if ({num, operator, save_enable, equ_enable, clear_enable, op_enable, key_ready, state_o} !==
          {e_num, e_op, e_save, e_equ, e_clr, e_open, e_ready, e_state}) begin
        errs++;
        if (errs <= 10)
          $display("FAIL random_%0d got num %0h op %0b save %0b equ %0b clr %0b open %0b rdy %0b st %0d want num %0h op %0b save %0b equ %0b clr %0b open %0b rdy %0b st %0d",
                   i, num, operator, save_enable, equ_enable, clear_enable, op_enable, key_ready, state_o,
                   e_num, e_op, e_save, e_equ, e_clr, e_open, e_ready, e_state);
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_calc();
    test_digit_limit();
    test_op_reselect();
    test_restart();
    test_calc_clear();
    test_rst_restart();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
